axi4_burst_mem_slave: RTL and testbench
=======================================

// Module: axi4_burst_mem_slave
// PURPOSE: AXI4-Full memory-mapped slave backed by an internal word array. It is the responder end for the 2D DMA's read master (AR/R) and write master (AW/W/B), used in simulation and on-chip as the DMA source/destination buffer. Read and write channels run independent FSMs with one outstanding burst per channel.
// PARAMETERS:
//   C_S_AXI_ID_WIDTH     1             ID width; IDs are echoed on BID/RID
//   C_S_AXI_ADDR_WIDTH   32            byte address width
//   C_S_AXI_DATA_WIDTH   32            data width; fixed 4-byte beats, INCR bursts only
//   C_MEM_DEPTH_WORDS    1024          array depth in words (power of 2); word index = ADDR[2 +: log2(depth)]
// PORTS:
//   S_AXI_ACLK     in   1     clock
//   S_AXI_ARESET   in   1     asynchronous reset, active-high
//   S_AXI_AWID     in   ID    write burst ID
//   S_AXI_AWADDR   in   ADDR  write start byte address (bits [1:0] ignored)
//   S_AXI_AWLEN    in   8     beats-1
//   S_AXI_AWVALID  in   1     AW valid
//   S_AXI_AWREADY  out  1     AW ready
//   S_AXI_WDATA    in   DATA  write data
//   S_AXI_WSTRB    in   DATA/8 byte enables
//   S_AXI_WLAST    in   1     last write beat
//   S_AXI_WVALID   in   1     W valid
//   S_AXI_WREADY   out  1     W ready
//   S_AXI_BID      out  ID    response ID (= captured AWID)
//   S_AXI_BRESP    out  2     write response
//   S_AXI_BVALID   out  1     B valid
//   S_AXI_BREADY   in   1     B ready
//   S_AXI_ARID     in   ID    read burst ID
//   S_AXI_ARADDR   in   ADDR  read start byte address
//   S_AXI_ARLEN    in   8     beats-1
//   S_AXI_ARVALID  in   1     AR valid
//   S_AXI_ARREADY  out  1     AR ready
//   S_AXI_RID      out  ID    read ID (= captured ARID)
//   S_AXI_RDATA    out  DATA  read data (registered)
//   S_AXI_RRESP    out  2     read response
//   S_AXI_RLAST    out  1     last read beat
//   S_AXI_RVALID   out  1     R valid
//   S_AXI_RREADY   in   1     R ready
// BEHAVIOUR:
// - Reset: all outputs 0, both FSMs idle, counters 0. Array contents are not reset. Reset mid-burst aborts the burst with no B/R completion.
// - Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. AWREADY=1 only in W_IDLE; the AW handshake captures addr/len/ID. WREADY=1 in W_DATA; each W handshake writes the WSTRB-masked word and increments the word address (wraps modulo depth). The beat counter reaching AWLEN ends the burst; WLAST is not used for termination. In W_RESP, BVALID=1 and is held until BREADY; the next AW is accepted no earlier than the cycle after the B handshake.
// - Read FSM R_IDLE->R_DATA->R_IDLE. ARREADY=1 only in R_IDLE. First RVALID comes the cycle after the AR handshake. RDATA/RLAST/RID are stable while RVALID && !RREADY. With RREADY held high, beats are back-to-back (1 beat/clk). RLAST=1 on beat ARLEN. The FSM returns to R_IDLE on the last beat handshake.
// - ARLEN/AWLEN=0: single beat. Length 256: counter is 8-bit and compares equal before wrapping.
// - Read and write in the same cycle to the same word: read returns the pre-write value.
// - BRESP/RRESP = OKAY unless the error feature below flags the transfer.
// CONFIGURATION: macro AXI4_MEM_SLAVE_ERR_RESP_EN.
//   Defined: a burst whose any beat falls outside [0, depth*4) returns SLVERR (2'b10). Out-of-range write beats are dropped; out-of-range read beats return 0. WLAST asserted on a non-final beat, or absent on the final beat, also forces BRESP=SLVERR.
//   Undefined: addresses wrap modulo depth, WLAST is ignored, and responses are always OKAY.
// STRUCTURE: package axi4_mem_pkg holds RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the W_/R_ state encodings. One sub-module, axi4_mem_array: a dual-port word RAM with byte-write enables and a synchronous read port, inferable as BRAM. Both FSMs stay in the top module.
// TESTING:
// - Write AWADDR=0x40, AWLEN=15, data 0x100..0x10F, WSTRB=0xF -> 16 WREADY beats, one BVALID with BRESP=0 and BID=AWID; a following ARADDR=0x40, ARLEN=15 read returns 0x100..0x10F with RLAST only on beat 16.
// - Same read with RREADY toggling 1,0,1,0 -> RDATA held while stalled, no beat lost or repeated, 16 beats total.
// - Write 0xAABBCCDD with WSTRB=0x5 over 0x11111111 -> read returns 0x11BB11DD.
// - AR and AW handshakes in the same cycle to the same word -> both accepted; the read sees the old value; BVALID and RVALID both follow.
// - Reset asserted during read beat 5 of 16 -> RVALID=0 immediately; after release, ARREADY=1 and a new burst works.
// - With AXI4_MEM_SLAVE_ERR_RESP_EN: ARADDR=depth*4-8, ARLEN=3 -> beats 3-4 have RRESP=2'b10 and RDATA=0; WLAST on beat 2 of 4 -> BRESP=2'b10.

Source files
------------

// File: rtl/axi4_burst_mem_slave_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi4_mem_pkg
// Description : Shared response codes, FSM state encodings and helpers for
//               the AXI4 burst memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   // Maps an error flag onto the AXI response code
   function automatic logic [1:0] resp_of(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_burst_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Interface   : axi4_burst_mem_slave_if
// Description : AXI4-Full AW/W/B/AR/R channel bundle with master and slave
//               views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_burst_mem_slave_if #(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32
);
   logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [7:0]                      S_AXI_AWLEN;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WLAST;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [7:0]                      S_AXI_ARLEN;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RLAST;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
      output S_AXI_RREADY
   );
endinterface
`default_nettype wire

// File: rtl/axi4_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : axi4_mem_array
// Description : Dual-port word RAM, one byte-masked write port and one
//               synchronous read port with read enable. A same-cycle read and
//               write to one word returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_mem_array #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           i_clk,
   input  logic [DATA_WIDTH/8-1:0]        i_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0]          i_wdata,
   input  logic                           i_re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0]          o_rdata
);

   localparam int C_NBYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Byte-masked write port
   always_ff @(posedge i_clk) begin
      for (int b = 0; b < C_NBYTES; b++) begin
         if (i_we[b]) begin
            r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   // Registered read port; holds its value while the enable is low
   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi4_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_mem_slave
// Description : AXI4-Full INCR-burst slave backed by an internal word RAM.
//               Independent read and write FSMs, one outstanding burst each.
//               Optional macro AXI4_MEM_SLAVE_ERR_RESP_EN enables SLVERR for
//               out-of-range beats and WLAST misplacement; without it,
//               addresses wrap modulo the depth and responses are OKAY.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_burst_mem_slave #(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_MEM_DEPTH_WORDS  = 1024
) (
   input logic                   S_AXI_ACLK,
   input logic                   S_AXI_ARESET,
   axi4_burst_mem_slave_if.slave s_axi
);
   import axi4_mem_pkg::*;

   localparam int C_MEM_AW = $clog2(C_MEM_DEPTH_WORDS);
   localparam int C_WA_W   = C_S_AXI_ADDR_WIDTH - 2;
   localparam int C_STRB_W = C_S_AXI_DATA_WIDTH / 8;

   // ---------------- write channel state ----------------
   wr_state_t                   r_wstate;
   logic                        r_awready;
   logic                        r_wready;
   logic                        r_bvalid;
   logic [1:0]                  r_bresp;
   logic [C_S_AXI_ID_WIDTH-1:0] r_bid;
   logic [C_WA_W-1:0]           r_waddr;
   logic [7:0]                  r_wcnt;
   logic [7:0]                  r_awlen;
   logic                        r_werr;

   // ---------------- read channel state ----------------
   rd_state_t                   r_rstate;
   logic                        r_arready;
   logic                        r_rvalid;
   logic                        r_rlast;
   logic [1:0]                  r_rresp;
   logic [C_S_AXI_ID_WIDTH-1:0] r_rid;
   logic [C_WA_W-1:0]           r_raddr;
   logic [7:0]                  r_rcnt;
   logic [7:0]                  r_arlen;
   logic                        r_roor;

   logic                          w_aw_hs;
   logic                          w_w_hs;
   logic                          w_w_last_beat;
   logic                          w_w_oor;
   logic                          w_w_beat_err;
   logic [C_STRB_W-1:0]           w_mem_we;
   logic                          w_ar_hs;
   logic                          w_r_hs;
   logic                          w_r_last;
   logic                          w_r_adv;
   logic                          w_rd_en;
   logic [C_WA_W-1:0]             w_rd_word;
   logic                          w_rd_oor;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_ram_q;
   logic                          w_unused;

   assign w_aw_hs       = s_axi.S_AXI_AWVALID && r_awready;
   assign w_w_hs        = s_axi.S_AXI_WVALID && r_wready;
   assign w_w_last_beat = (r_wcnt == r_awlen);

   assign w_ar_hs   = s_axi.S_AXI_ARVALID && r_arready;
   assign w_r_hs    = r_rvalid && s_axi.S_AXI_RREADY;
   assign w_r_last  = (r_rcnt == r_arlen);
   // A new RAM read is launched on the AR handshake and on every accepted
   // non-final beat, so RDATA only moves when the master takes a beat.
   assign w_r_adv   = w_r_hs && !w_r_last;
   assign w_rd_en   = w_ar_hs || w_r_adv;
   assign w_rd_word = (r_rstate == R_IDLE) ? s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]
                                           : r_raddr;

`ifdef AXI4_MEM_SLAVE_ERR_RESP_EN
   // Any word-address bit above the array index means the beat is outside the array
   assign w_w_oor      = |r_waddr[C_WA_W-1:C_MEM_AW];
   assign w_rd_oor     = |w_rd_word[C_WA_W-1:C_MEM_AW];
   assign w_w_beat_err = w_w_oor || (s_axi.S_AXI_WLAST != w_w_last_beat);
   assign w_unused     = &{1'b0, s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
`else
   assign w_w_oor      = 1'b0;
   assign w_rd_oor     = 1'b0;
   assign w_w_beat_err = 1'b0;
   assign w_unused     = &{1'b0, s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                           s_axi.S_AXI_WLAST};
`endif

   // Dropped (out-of-range) beats still complete the handshake but never reach the RAM
   assign w_mem_we = (w_w_hs && !w_w_oor) ? s_axi.S_AXI_WSTRB : '0;

   axi4_mem_array #(
      .DATA_WIDTH  (C_S_AXI_DATA_WIDTH),
      .DEPTH_WORDS (C_MEM_DEPTH_WORDS)
   ) u_mem (
      .i_clk   (S_AXI_ACLK),
      .i_we    (w_mem_we),
      .i_waddr (r_waddr[C_MEM_AW-1:0]),
      .i_wdata (s_axi.S_AXI_WDATA),
      .i_re    (w_rd_en),
      .i_raddr (w_rd_word[C_MEM_AW-1:0]),
      .o_rdata (w_ram_q)
   );

   // Write FSM: accept AW, count W beats up to AWLEN, then hold B until taken
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_bid     <= '0;
         r_waddr   <= '0;
         r_wcnt    <= '0;
         r_awlen   <= '0;
         r_werr    <= 1'b0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_waddr   <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                  r_awlen   <= s_axi.S_AXI_AWLEN;
                  r_bid     <= s_axi.S_AXI_AWID;
                  r_wcnt    <= '0;
                  r_werr    <= 1'b0;
                  r_wstate  <= W_DATA;
               end else begin
                  r_awready <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_w_hs) begin
                  r_waddr <= r_waddr + 1'b1;
                  if (w_w_last_beat) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= resp_of(r_werr || w_w_beat_err);
                     r_wstate <= W_RESP;
                  end else begin
                     r_wcnt <= r_wcnt + 8'd1;
                     r_werr <= r_werr || w_w_beat_err;
                  end
               end
            end
            W_RESP: begin
               if (s_axi.S_AXI_BREADY) begin
                  r_bvalid  <= 1'b0;
                  r_bresp   <= RESP_OKAY;
                  r_awready <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // Read FSM: AR launches the first RAM read; each accepted beat launches the next
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rid     <= '0;
         r_raddr   <= '0;
         r_rcnt    <= '0;
         r_arlen   <= '0;
         r_roor    <= 1'b0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_arready <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_rid     <= s_axi.S_AXI_ARID;
                  r_arlen   <= s_axi.S_AXI_ARLEN;
                  r_rcnt    <= '0;
                  r_rlast   <= (s_axi.S_AXI_ARLEN == 8'd0);
                  r_roor    <= w_rd_oor;
                  r_rresp   <= resp_of(w_rd_oor);
                  r_raddr   <= w_rd_word + 1'b1;
                  r_rstate  <= R_DATA;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (w_r_hs) begin
                  if (w_r_last) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_rresp   <= RESP_OKAY;
                     r_roor    <= 1'b0;
                     r_arready <= 1'b1;
                     r_rstate  <= R_IDLE;
                  end else begin
                     r_rcnt  <= r_rcnt + 8'd1;
                     r_rlast <= ((r_rcnt + 8'd1) == r_arlen);
                     r_roor  <= w_rd_oor;
                     r_rresp <= resp_of(w_rd_oor);
                     r_raddr <= r_raddr + 1'b1;
                  end
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign s_axi.S_AXI_AWREADY = r_awready;
   assign s_axi.S_AXI_WREADY  = r_wready;
   assign s_axi.S_AXI_BVALID  = r_bvalid;
   assign s_axi.S_AXI_BRESP   = r_bresp;
   assign s_axi.S_AXI_BID     = r_bid;
   assign s_axi.S_AXI_ARREADY = r_arready;
   assign s_axi.S_AXI_RVALID  = r_rvalid;
   assign s_axi.S_AXI_RLAST   = r_rlast;
   assign s_axi.S_AXI_RRESP   = r_rresp;
   assign s_axi.S_AXI_RID     = r_rid;
   // RAM output register is not reset, so it is masked outside valid beats;
   // out-of-range beats read as zero.
   assign s_axi.S_AXI_RDATA   = (r_rvalid && !r_roor) ? w_ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_burst_mem_slave
// Description : Self-checking bench for axi4_burst_mem_slave. Expected read
//               beats are queued at AR issue from a bench-side memory model
//               and popped as R beats are accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_mem_slave;

   localparam int DEPTH = 1024;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [1:0]  resp;
      logic        id;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   sb_t  sb[$];
   logic [31:0] model [DEPTH];
   logic [31:0] wdat  [256];
   time  aw_hs_time;
   time  ar_hs_time;

   axi4_burst_mem_slave_if bus ();

   axi4_burst_mem_slave dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .s_axi        (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic axi_write(input logic id, input logic [31:0] addr, input int len,
                            input logic [3:0] strb, input int wlast_at,
                            input logic [1:0] exp_bresp);
      int beat;
      int cyc;
      @(negedge clk);
      bus.S_AXI_AWID = id; bus.S_AXI_AWADDR = addr;
      bus.S_AXI_AWLEN = 8'(len); bus.S_AXI_AWVALID = 1'b1;
      cyc = 0;
      while (!bus.S_AXI_AWREADY && cyc < 50) begin @(negedge clk); cyc++; end
      n_cmp++;
      if (bus.S_AXI_AWREADY !== 1'b1) begin
         n_err++; $display("FAIL aw_timeout: awready=%b required 1", bus.S_AXI_AWREADY);
         bus.S_AXI_AWVALID = 1'b0; return;
      end
      aw_hs_time = $time;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      beat = 0; cyc = 0;
      while (beat <= len && cyc < 600) begin
         bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = wdat[beat];
         bus.S_AXI_WSTRB = strb;  bus.S_AXI_WLAST = (beat == wlast_at);
         if (bus.S_AXI_WREADY) beat++;
         @(negedge clk); cyc++;
      end
      bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
      n_cmp++;
      if (beat != len + 1) begin
         n_err++; $display("FAIL w_beats: got %0d beats required %0d", beat, len + 1);
      end
      n_cmp++;
      if (bus.S_AXI_WREADY !== 1'b0) begin
         n_err++; $display("FAIL w_ready_after_last: got %b required 0", bus.S_AXI_WREADY);
      end
      bus.S_AXI_BREADY = 1'b1; cyc = 0;
      while (!bus.S_AXI_BVALID && cyc < 50) begin @(negedge clk); cyc++; end
      n_cmp++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_BID} !== {1'b1, exp_bresp, id}) begin
         n_err++;
         $display("FAIL b_resp: got valid=%b resp=%b id=%b required valid=1 resp=%b id=%b",
                  bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_BID, exp_bresp, id);
      end
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      n_cmp++;
      if (bus.S_AXI_BVALID !== 1'b0) begin
         n_err++; $display("FAIL b_single: bvalid=%b after handshake required 0", bus.S_AXI_BVALID);
      end
   endtask

   task automatic axi_read(input logic id, input logic [31:0] addr, input int len,
                           input bit toggle, output int rv_cycles);
      sb_t  e;
      int   wi;
      int   beats;
      int   cyc;
      bit   stalled;
      logic [31:0] held_d;
      logic held_l;
      rv_cycles = 0;
      for (int i = 0; i <= len; i++) begin
         wi = int'(addr >> 2) + i;
         e.id = id; e.last = (i == len);
`ifdef AXI4_MEM_SLAVE_ERR_RESP_EN
         if (wi >= DEPTH) begin e.data = 32'h0; e.resp = 2'b10; end
         else begin e.data = model[wi]; e.resp = 2'b00; end
`else
         e.data = model[wi % DEPTH]; e.resp = 2'b00;
`endif
         sb.push_back(e);
      end
      @(negedge clk);
      bus.S_AXI_ARID = id; bus.S_AXI_ARADDR = addr;
      bus.S_AXI_ARLEN = 8'(len); bus.S_AXI_ARVALID = 1'b1;
      cyc = 0;
      while (!bus.S_AXI_ARREADY && cyc < 50) begin @(negedge clk); cyc++; end
      n_cmp++;
      if (bus.S_AXI_ARREADY !== 1'b1) begin
         n_err++; $display("FAIL ar_timeout: arready=%b required 1", bus.S_AXI_ARREADY);
         bus.S_AXI_ARVALID = 1'b0; sb.delete(); return;
      end
      ar_hs_time = $time;
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      n_cmp++;
      if (bus.S_AXI_RVALID !== 1'b1) begin
         n_err++; $display("FAIL r_first_latency: rvalid=%b one cycle after AR required 1", bus.S_AXI_RVALID);
      end
      beats = 0; cyc = 0; stalled = 0;
      while (beats <= len && cyc < 600) begin
         bus.S_AXI_RREADY = toggle ? (cyc % 2 == 0) : 1'b1;
         if (bus.S_AXI_RVALID) begin
            rv_cycles++;
            if (stalled) begin
               n_cmp++;
               if ({bus.S_AXI_RDATA, bus.S_AXI_RLAST} !== {held_d, held_l}) begin
                  n_err++;
                  $display("FAIL r_hold: got %h/%b required %h/%b", bus.S_AXI_RDATA,
                           bus.S_AXI_RLAST, held_d, held_l);
               end
            end
            if (bus.S_AXI_RREADY) begin
               n_cmp++;
               if (sb.size() == 0) begin
                  n_err++; $display("FAIL r_extra_beat: got data %h required no beat", bus.S_AXI_RDATA);
               end else begin
                  e = sb.pop_front();
                  if ({bus.S_AXI_RDATA, bus.S_AXI_RLAST, bus.S_AXI_RRESP, bus.S_AXI_RID} !==
                      {e.data, e.last, e.resp, e.id}) begin
                     n_err++;
                     $display("FAIL r_beat%0d: got data=%h last=%b resp=%b id=%b required data=%h last=%b resp=%b id=%b",
                              beats, bus.S_AXI_RDATA, bus.S_AXI_RLAST, bus.S_AXI_RRESP, bus.S_AXI_RID,
                              e.data, e.last, e.resp, e.id);
                  end
               end
               beats++; stalled = 0;
            end else begin
               stalled = 1; held_d = bus.S_AXI_RDATA; held_l = bus.S_AXI_RLAST;
            end
         end
         @(negedge clk); cyc++;
      end
      bus.S_AXI_RREADY = 1'b0;
      n_cmp++;
      if (beats != len + 1) begin
         n_err++; $display("FAIL r_beats: got %0d beats required %0d", beats, len + 1);
         sb.delete();
      end
      n_cmp++;
      if (bus.S_AXI_RVALID !== 1'b0) begin
         n_err++; $display("FAIL r_no_extra: rvalid=%b after last beat required 0", bus.S_AXI_RVALID);
      end
   endtask

   task automatic test_reset();
      int cyc;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_BID,
           bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_RRESP, bus.S_AXI_RID,
           bus.S_AXI_RDATA} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: awr=%b wr=%b bv=%b arr=%b rv=%b rl=%b rdata=%h required all 0",
                  bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
                  bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_RDATA);
      end
      rst = 1'b0; cyc = 0;
      while (!(bus.S_AXI_AWREADY && bus.S_AXI_ARREADY) && cyc < 5) begin @(negedge clk); cyc++; end
      n_cmp++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== 2'b11) begin
         n_err++; $display("FAIL ready_after_reset: got awready=%b arready=%b required 1/1",
                           bus.S_AXI_AWREADY, bus.S_AXI_ARREADY);
      end
   endtask

   task automatic test_incr_burst();
      int rvc;
      for (int i = 0; i < 16; i++) wdat[i] = 32'h100 + i;
      axi_write(1'b1, 32'h40, 15, 4'hF, 15, 2'b00);
      for (int i = 0; i < 16; i++) model[16 + i] = 32'h100 + i;
      axi_read(1'b1, 32'h40, 15, 1'b0, rvc);
      n_cmp++;
      if (rvc != 16) begin
         n_err++; $display("FAIL r_back_to_back: got %0d valid cycles required 16", rvc);
      end
   endtask

   task automatic test_rready_stall();
      int rvc;
      axi_read(1'b0, 32'h40, 15, 1'b1, rvc);
      n_cmp++;
      if (rvc != 31) begin
         n_err++; $display("FAIL r_stall_cycles: got %0d valid cycles required 31", rvc);
      end
   endtask

   task automatic test_strobe();
      int rvc;
      wdat[0] = 32'h11111111;
      axi_write(1'b0, 32'h100, 0, 4'hF, 0, 2'b00);
      wdat[0] = 32'hAABBCCDD;
      axi_write(1'b0, 32'h100, 0, 4'h5, 0, 2'b00);
      model[64] = 32'h11BB11DD;
      axi_read(1'b0, 32'h100, 0, 1'b0, rvc);
   endtask

   task automatic test_same_cycle();
      int rvc_a;
      int rvc_b;
      wdat[0] = 32'h12345678;
      axi_write(1'b0, 32'h200, 0, 4'hF, 0, 2'b00);
      model[128] = 32'h12345678;
      wdat[0] = 32'hCAFEF00D;
      fork
         axi_write(1'b1, 32'h200, 0, 4'hF, 0, 2'b00);
         axi_read(1'b1, 32'h200, 0, 1'b0, rvc_a);
      join
      n_cmp++;
      if (aw_hs_time != ar_hs_time) begin
         n_err++; $display("FAIL same_cycle_accept: aw at %0t ar at %0t required equal", aw_hs_time, ar_hs_time);
      end
      model[128] = 32'hCAFEF00D;
      axi_read(1'b0, 32'h200, 0, 1'b0, rvc_b);
   endtask

   task automatic test_reset_mid_read();
      int beats;
      int cyc;
      int rvc;
      for (int i = 0; i < 16; i++) wdat[i] = 32'h500 + i;
      axi_write(1'b0, 32'h400, 15, 4'hF, 15, 2'b00);
      @(negedge clk);
      bus.S_AXI_ARID = 1'b0; bus.S_AXI_ARADDR = 32'h400;
      bus.S_AXI_ARLEN = 8'd15; bus.S_AXI_ARVALID = 1'b1;
      cyc = 0;
      while (!bus.S_AXI_ARREADY && cyc < 50) begin @(negedge clk); cyc++; end
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
      beats = 0; cyc = 0;
      while (beats < 4 && cyc < 100) begin
         if (bus.S_AXI_RVALID) begin
            n_cmp++;
            if (bus.S_AXI_RDATA !== 32'h500 + beats) begin
               n_err++; $display("FAIL rst_pre_beat%0d: got %h required %h", beats,
                                 bus.S_AXI_RDATA, 32'h500 + beats);
            end
            beats++;
         end
         @(negedge clk); cyc++;
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_ARREADY, bus.S_AXI_RDATA} !== '0) begin
         n_err++; $display("FAIL rst_mid_read: got rvalid=%b rlast=%b arready=%b rdata=%h required 0",
                           bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_ARREADY, bus.S_AXI_RDATA);
      end
      repeat (2) @(negedge clk);
      bus.S_AXI_RREADY = 1'b0; rst = 1'b0; cyc = 0;
      while (!bus.S_AXI_ARREADY && cyc < 5) begin @(negedge clk); cyc++; end
      n_cmp++;
      if (bus.S_AXI_ARREADY !== 1'b1) begin
         n_err++; $display("FAIL arready_after_rst: got %b required 1", bus.S_AXI_ARREADY);
      end
      axi_read(1'b1, 32'h40, 3, 1'b0, rvc);
   endtask

`ifdef AXI4_MEM_SLAVE_ERR_RESP_EN
   task automatic test_err_resp();
      int rvc;
      wdat[0] = 32'hD0D00001; wdat[1] = 32'hD0D00002;
      axi_write(1'b0, DEPTH * 4 - 8, 1, 4'hF, 1, 2'b00);
      model[DEPTH-2] = 32'hD0D00001; model[DEPTH-1] = 32'hD0D00002;
      axi_read(1'b0, DEPTH * 4 - 8, 3, 1'b0, rvc);
      for (int i = 0; i < 4; i++) wdat[i] = 32'hE0E00000 + i;
      axi_write(1'b1, 32'h80, 3, 4'hF, 1, 2'b10);
      for (int i = 0; i < 4; i++) model[32 + i] = 32'hE0E00000 + i;
      axi_read(1'b1, 32'h80, 3, 1'b0, rvc);
   endtask
`endif

   initial begin
      bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      test_reset();
      test_incr_burst();
      test_rready_stall();
      test_strobe();
      test_same_cycle();
      test_reset_mid_read();
`ifdef AXI4_MEM_SLAVE_ERR_RESP_EN
      test_err_resp();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
